// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state/size encodings, byte-enable constants and lane helpers for lsu_align.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // Both size flags set is treated as a full word, same as neither.
   function automatic size_t decode_size(input logic lb, input logic lh);
      if (lb && !lh)
         return SZ_BYTE;
      else if (lh && !lb)
         return SZ_HALF;
      else
         return SZ_WORD;
   endfunction

   function automatic logic [3:0] byte_en(input size_t size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return BE_BYTE << off;
         SZ_HALF: return BE_HALF << {off[1], 1'b0};
         default: return BE_WORD;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input size_t size, input logic [31:0] data);
      case (size)
         SZ_BYTE: return {4{data[7:0]}};
         SZ_HALF: return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

   function automatic logic is_misaligned(input size_t size, input logic [1:0] off);
      case (size)
         SZ_HALF: return off[0];
         SZ_WORD: return (off != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_fmt.sv
// lsu_lane_fmt: picks the addressed byte/halfword lane of a memory word and sign/zero-extends it.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module lsu_lane_fmt
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  size_t            size,
   input  logic             sign,
   input  logic [1:0]       offset,
   input  logic [XLEN-1:0]  word,
   output logic [XLEN-1:0]  result
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = 8'h00;
      lane_h = 16'h0000;
      result = '0;
      case (offset)
         2'd0:    lane_b = word[7:0];
         2'd1:    lane_b = word[15:8];
         2'd2:    lane_b = word[23:16];
         default: lane_b = word[31:24];
      endcase
      // Halfword lane is chosen by addr[1] only; addr[0] never shifts it.
      lane_h = offset[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: result = {{(XLEN-8){sign & lane_b[7]}}, lane_b};
         SZ_HALF: result = {{(XLEN-16){sign & lane_h[15]}}, lane_h};
         default: result = word;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/lsu_align.sv
// lsu_align: load/store unit issuing one req/ack memory transaction per access with lane alignment.
// Revision: 1.0 -- optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
`default_nettype none
`timescale 1ns/1ps

module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              we,
   input  logic              lb,
   input  logic              lh,
   input  logic              lbu,
   input  logic              lhu,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   rdata,
   output logic              done,
   output logic              busy,
   output logic              misalign,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_ack,
   input  logic [XLEN-1:0]   mem_rdata
);

   state_t          state;
   size_t           size_q;
   logic            sign_q;
   logic [1:0]      off_q;
   logic            we_q;

   size_t           size_in;
   logic            sign_in;
   logic            mis_in;
   logic [XLEN-1:0] load_fmt;

   assign size_in = decode_size(lb, lh);
   assign sign_in = ~(lbu | lhu);

`ifdef MISALIGN_TRAP_EN
   assign mis_in = is_misaligned(size_in, addr[1:0]);
`else
   assign mis_in = 1'b0;
`endif

   lsu_lane_fmt #(
      .XLEN(XLEN)
   ) u_lane_fmt (
      .size   (size_q),
      .sign   (sign_q),
      .offset (off_q),
      .word   (mem_rdata),
      .result (load_fmt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         size_q    <= SZ_WORD;
         sign_q    <= 1'b0;
         off_q     <= 2'b00;
         we_q      <= 1'b0;
         rdata     <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         misalign  <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'b0000;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  size_q <= size_in;
                  sign_q <= sign_in;
                  off_q  <= addr[1:0];
                  we_q   <= we;
                  busy   <= 1'b1;
                  if (mis_in) begin
                     // Trapped access never reaches memory; report it straight away.
                     state    <= DONE;
                     done     <= 1'b1;
                     misalign <= 1'b1;
                     rdata    <= '0;
                  end else begin
                     state     <= REQ;
                     mem_req   <= 1'b1;
                     mem_we    <= we;
                     mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                     mem_be    <= byte_en(size_in, addr[1:0]);
                     mem_wdata <= store_lanes(size_in, wdata);
                  end
               end
            end
            REQ: begin
               if (mem_ack) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  done    <= 1'b1;
                  if (!we_q)
                     rdata <= load_fmt;
               end
            end
            DONE: begin
               state    <= IDLE;
               done     <= 1'b0;
               busy     <= 1'b0;
               misalign <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lsu_align.sv
// tb_lsu_align: scoreboard bench for lsu_align with a cycle-driven memory responder.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_lsu_align;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        we = 1'b0;
   logic        lb = 1'b0, lh = 1'b0, lbu = 1'b0, lhu = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        done, busy, misalign;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   localparam logic [3:0] F_W   = 4'b0000;
   localparam logic [3:0] F_B   = 4'b1000;
   localparam logic [3:0] F_BU  = 4'b1010;
   localparam logic [3:0] F_H   = 4'b0100;
   localparam logic [3:0] F_HU  = 4'b0101;
   localparam logic [3:0] F_BH  = 4'b1100;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   logic [31:0] last_rdata = '0;

   always #5 clk = ~clk;

   lsu_align #(
      .XLEN   (32),
      .ADDR_W (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .we        (we),
      .lb        (lb),
      .lh        (lh),
      .lbu       (lbu),
      .lhu       (lhu),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .done      (done),
      .busy      (busy),
      .misalign  (misalign),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model of the alignment rules, written from the access semantics.
   function automatic logic [31:0] m_load(input logic [3:0] f, input logic [1:0] o, input logic [31:0] m);
      logic [7:0]  b;
      logic [15:0] h;
      logic        u;
      u = f[1] | f[0];
      b = 8'(m >> (32'(o) * 8));
      h = o[1] ? m[31:16] : m[15:0];
      if (f[3] && !f[2]) return u ? {24'h0, b} : {{24{b[7]}}, b};
      if (f[2] && !f[3]) return u ? {16'h0, h} : {{16{h[15]}}, h};
      return m;
   endfunction

   function automatic logic [3:0] m_be(input logic [3:0] f, input logic [1:0] o);
      if (f[3] && !f[2]) return 4'(1 << o);
      if (f[2] && !f[3]) return o[1] ? 4'b1100 : 4'b0011;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wd(input logic [3:0] f, input logic [31:0] w);
      if (f[3] && !f[2]) return {w[7:0], w[7:0], w[7:0], w[7:0]};
      if (f[2] && !f[3]) return {w[15:0], w[15:0]};
      return w;
   endfunction

   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_done", 32'(done), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_rdata", rdata, mon_e.rdata);
            chk("sb_misalign", 32'(misalign), 32'(mon_e.mis));
         end
      end
   end

   // One full access; all driving and sampling happens on the falling edge.
   task automatic access(input logic w, input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mrd, input int dly,
                         input bit poke_busy, input bit poke_done);
      exp_t        e;
      logic [3:0]  xbe;
      logic [31:0] xwd;
      xbe = m_be(f, a[1:0]);
      xwd = m_wd(f, wd);
      e.rdata = w ? last_rdata : m_load(f, a[1:0], mrd);
      e.mis = 1'b0;
      last_rdata = e.rdata;
      @(negedge clk);
      we = w; {lb, lh, lbu, lhu} = f; addr = a; wdata = wd; start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0; addr = ~a; wdata = ~wd; we = ~w;
      chk("req_c1", 32'(mem_req), 32'd1);
      chk("busy_c1", 32'(busy), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(w));
      chk("mem_addr", mem_addr, {a[31:2], 2'b00});
      chk("mem_be", 32'(mem_be), 32'(xbe));
      chk("mem_wdata", mem_wdata, xwd);
      for (int k = 0; k < dly; k++) begin
         mem_ack = 1'b0;
         if (poke_busy && k == 0) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("req_hold", 32'(mem_req), 32'd1);
         chk("be_hold", 32'(mem_be), 32'(xbe));
         chk("wd_hold", mem_wdata, xwd);
         chk("done_early", 32'(done), 32'd0);
      end
      mem_ack = 1'b1; mem_rdata = mrd;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      chk("done_lat", 32'(done), 32'd1);
      chk("busy_done", 32'(busy), 32'd1);
      chk("req_drop", 32'(mem_req), 32'd0);
      if (poke_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_pulse", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      @(negedge clk);
      chk("no_reissue", 32'(mem_req), 32'd0);
   endtask

   task automatic trap(input logic [3:0] f, input logic [31:0] a);
      exp_t e;
      e.rdata = 32'h0;
      e.mis = 1'b1;
      last_rdata = 32'h0;
      @(negedge clk);
      we = 1'b0; {lb, lh, lbu, lhu} = f; addr = a; start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("trap_done", 32'(done), 32'd1);
      chk("trap_mis", 32'(misalign), 32'd1);
      chk("trap_noreq", 32'(mem_req), 32'd0);
      chk("trap_rdata", rdata, 32'h0);
      @(negedge clk);
      chk("trap_done_off", 32'(done), 32'd0);
      chk("trap_mis_off", 32'(misalign), 32'd0);
      chk("trap_busy_off", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0]  rf;
      logic [31:0] ra;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mis", 32'(misalign), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_be", 32'(mem_be), 32'd0);
      chk("rst_wdata", mem_wdata, 32'h0);

      access(1'b0, F_W,  32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 1'b0);
      access(1'b0, F_B,  32'h103, 32'h0, 32'h80FF_0000, 0, 1'b0, 1'b0);
      access(1'b0, F_BU, 32'h103, 32'h0, 32'h80FF_0000, 1, 1'b0, 1'b0);
      access(1'b0, F_H,  32'h102, 32'h0, 32'h80FF_1234, 0, 1'b0, 1'b0);
      access(1'b0, F_HU, 32'h200, 32'h0, 32'h1111_F00D, 2, 1'b0, 1'b0);
      access(1'b0, F_BH, 32'h204, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
      access(1'b1, F_H,  32'h202, 32'h1234ABCD, 32'h5555_5555, 3, 1'b1, 1'b0);
      access(1'b1, F_B,  32'h301, 32'h0000_00A5, 32'h0, 1, 1'b0, 1'b1);
      access(1'b1, F_W,  32'h304, 32'h0BAD_CAFE, 32'h0, 0, 1'b0, 1'b0);

      // Acknowledge while idle must not produce any transaction.
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("idle_ack_done", 32'(done), 32'd0);
      chk("idle_ack_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("idle_ack_done2", 32'(done), 32'd0);

      // Reset while waiting for the acknowledge aborts without a done pulse.
      @(negedge clk);
      we = 1'b0; {lb, lh, lbu, lhu} = F_W; addr = 32'h400; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("abort_req", 32'(mem_req), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      last_rdata = 32'h0;
      chk("abort_req_off", 32'(mem_req), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_rdata", rdata, 32'h0);
      repeat (2) @(negedge clk);
      access(1'b0, F_W, 32'h400, 32'h0, 32'h7654_3210, 1, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         case (i % 3)
            0:       rf = ($urandom_range(0, 1) != 0) ? F_B : F_BU;
            1:       rf = ($urandom_range(0, 1) != 0) ? F_H : F_HU;
            default: rf = F_W;
         endcase
         ra = $urandom;
         if (rf[2]) ra[0] = 1'b0;
         if (rf == F_W) ra[1:0] = 2'b00;
         access(1'b0, rf, ra, 32'h0, $urandom, int'($urandom_range(0, 2)), 1'b0, 1'b0);
      end

`ifdef MISALIGN_TRAP_EN
      trap(F_H, 32'h101);
      access(1'b0, F_W, 32'h500, 32'h0, 32'h1357_9BDF, 0, 1'b0, 1'b0);
      trap(F_W, 32'h502);
`else
      access(1'b0, F_H, 32'h101, 32'h0, 32'hAAAA_8001, 0, 1'b0, 1'b0);
      access(1'b0, F_W, 32'h103, 32'h0, 32'h2468_ACE0, 1, 1'b0, 1'b0);
      chk("no_trap_mis", 32'(misalign), 32'd0);
`endif

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
